fp16_normalize_stage: RTL and testbench

//  Two-stage pipelined normalizer for the SD4 FP16 MAC datapath; sits directly upstream of subnormal_handling.

---
 rtl/mac_fp16_pkg.sv | 10 +
 rtl/fp16_normalize_stage_lod.sv | 18 +
 rtl/fp16_normalize_stage.sv | 142 ++++++++++++++
 tb/tb_fp16_normalize_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_fp16_pkg.sv
// Shared constants for the SD4 FP16 MAC datapath.
// Exponents are signed two's complement, biased by FP16_BIAS.
package mac_fp16_pkg;
  localparam int FP16_BIAS = 15;
  localparam int SUM_W     = 24;
  localparam int MANT_W    = 11;
  localparam int EXP_W     = 7;
  localparam int EXP_MAX   = 63;
  localparam int EXP_MIN   = -64;
endpackage

// File: rtl/fp16_normalize_stage_lod.sv
// Leading-one detector: position of the highest set bit.
// zero is asserted when no bit is set (pos is then 0).
module lod #(
  parameter int W   = 24,
  parameter int PW  = $clog2(W)
) (
  input  logic [W-1:0]  in,
  output logic [PW-1:0] pos,
  output logic          zero
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (in[i]) pos = PW'(i);
    end
    zero = ~|in;
  end
endmodule

// File: rtl/fp16_normalize_stage.sv
// Two-stage FP16 normalizer: S1 finds the leading one, S2 shifts/rounds.
// NORM_ROUND_RNE_EN selects round-to-nearest-even; default truncates.
module fp16_normalize_stage
  import mac_fp16_pkg::*;
#(
  parameter int SUM_W_P  = SUM_W,
  parameter int MANT_W_P = MANT_W,
  parameter int EXP_W_P  = EXP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [SUM_W_P-1:0]  in_mag,
  input  logic [EXP_W_P-1:0]  in_exp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sign,
  output logic [MANT_W_P-1:0] norm_sum,
  output logic [EXP_W_P-1:0]  exp_final,
  output logic                is_zero
);
  localparam int PW  = $clog2(SUM_W_P);
  localparam int MW1 = MANT_W_P - 1;
  localparam int XW  = EXP_W_P + 2;

  logic               s1_valid_q, s1_sign_q, s1_zero_q;
  logic [SUM_W_P-1:0] s1_mag_q;
  logic [EXP_W_P-1:0] s1_exp_q;
  logic [PW-1:0]      s1_pos_q;
  logic [PW-1:0]      lod_pos;
  logic               lod_zero;

  logic                out_valid_q, sign_q, zero_q;
  logic [MANT_W_P-1:0] norm_q, norm_d;
  logic [EXP_W_P-1:0]  exp_q, exp_d;

  logic s1_en, s2_en;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  lod #(.W(SUM_W_P), .PW(PW)) u_lod (
    .in   (in_mag),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  logic [PW-1:0]       sh;
  logic [MANT_W_P-1:0] mant, mant_r;
  logic                carry;
  logic [XW-1:0]       e_w;
`ifdef NORM_ROUND_RNE_EN
  logic [SUM_W_P-1:0]  low;
  logic                guard, sticky, inc;
  logic [MANT_W_P:0]   rnd;
`endif

  always_comb begin
    sh   = '0;
    mant = '0;
    if (s1_pos_q >= PW'(MW1)) begin
      sh   = s1_pos_q - PW'(MW1);
      mant = MANT_W_P'(s1_mag_q >> sh);
    end else begin
      mant = MANT_W_P'(s1_mag_q << (PW'(MW1) - s1_pos_q));
    end
`ifdef NORM_ROUND_RNE_EN
    // low covers every bit shifted out; its top bit is the guard
    low    = (SUM_W_P'(1) << sh) - SUM_W_P'(1);
    guard  = |(s1_mag_q & (low ^ (low >> 1)));
    sticky = |(s1_mag_q & (low >> 1));
    inc    = guard & (sticky | mant[0]);
    rnd    = {1'b0, mant} + (MANT_W_P + 1)'(inc);
    carry  = rnd[MANT_W_P];
    mant_r = carry ? {1'b1, {MW1{1'b0}}}
                   : rnd[MANT_W_P-1:0];
`else
    carry  = 1'b0;
    mant_r = mant;
`endif
    e_w = {{2{s1_exp_q[EXP_W_P-1]}}, s1_exp_q}
        + XW'(s1_pos_q)
        - XW'(SUM_W_P - 2)
        + XW'(carry);
    if ($signed(e_w) > EXP_MAX)
      exp_d = EXP_W_P'(EXP_MAX);
    else if ($signed(e_w) < EXP_MIN)
      exp_d = EXP_W_P'(EXP_MIN);
    else
      exp_d = e_w[EXP_W_P-1:0];
    norm_d = mant_r;
    if (s1_zero_q) begin
      exp_d  = '0;
      norm_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_exp_q    <= '0;
      s1_pos_q    <= '0;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      norm_q      <= '0;
      exp_q       <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q <= in_sign;
          s1_mag_q  <= in_mag;
          s1_exp_q  <= in_exp;
          s1_pos_q  <= lod_pos;
          s1_zero_q <= lod_zero;
        end
      end
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sign_q <= s1_sign_q;
          zero_q <= s1_zero_q;
          norm_q <= norm_d;
          exp_q  <= exp_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sign      = sign_q;
  assign is_zero   = zero_q;
  assign norm_sum  = norm_q;
  assign exp_final = exp_q;
endmodule

// File: tb/tb_fp16_normalize_stage.sv
// Randomized self-checking bench for fp16_normalize_stage.
// Rounding expectations follow NORM_ROUND_RNE_EN.
module tb_fp16_normalize_stage;
  logic        clk = 0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [23:0] in_mag;
  logic [6:0]  in_exp;
  logic        out_valid, out_ready;
  logic        sign, is_zero;
  logic [10:0] norm_sum;
  logic [6:0]  exp_final;

  int n_chk = 0;
  int n_err = 0;

  fp16_normalize_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .norm_sum  (norm_sum),
    .exp_final (exp_final),
    .is_zero   (is_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {sign, is_zero, norm[10:0], exp[6:0]}
  function automatic logic [19:0] model(input logic s,
                                        input logic [23:0] mag,
                                        input logic [6:0] e);
    int p, sh, m, mant, rem, half, ex;
    bit inc;
    logic [6:0] eo;
    if (mag == 0) return {s, 1'b1, 11'd0, 7'd0};
    p = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    m = int'(mag);
    inc = 0;
    if (p >= 10) begin
      sh = p - 10;
      mant = m / (1 << sh);
      rem = m % (1 << sh);
`ifdef NORM_ROUND_RNE_EN
      if (sh > 0) begin
        half = 1 << (sh - 1);
        inc = (rem > half) || (rem == half && (mant % 2) == 1);
      end
`endif
    end else begin
      mant = m * (1 << (10 - p));
    end
    ex = int'($signed(e)) + p - 22;
    mant = mant + int'(inc);
    if (mant == 2048) begin
      mant = 1024;
      ex = ex + 1;
    end
    if (ex > 63) ex = 63;
    if (ex < -64) ex = -64;
    eo = 7'(ex);
    return {s, 1'b0, 11'(mant), eo};
  endfunction

  typedef struct packed {
    logic        s;
    logic [23:0] mag;
    logic [6:0]  e;
  } beat_t;

  beat_t       stim_q[$];
  logic [19:0] exp_q[$];
  logic        prev_stall;
  logic [19:0] prev_out;

  function automatic logic [19:0] cur_out();
    return {sign, is_zero, norm_sum, exp_final};
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic ordy);
    logic [19:0] e;
    out_ready = ordy;
    if (stim_q.size() > 0) begin
      in_valid = 1;
      {in_sign, in_mag, in_exp} = stim_q[0];
    end else begin
      in_valid = 0;
    end
    #1;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'(cur_out()), 32'(prev_out));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 32'(cur_out()), 32'(e));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out = cur_out();
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_sign, in_mag, in_exp));
      void'(stim_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < 500) begin
      step(1'b1);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    int k;
    b.s = 1'($urandom);
    b.e = 7'($urandom);
    k = $urandom_range(0, 4);
    case (k)
      0: b.mag = 24'($urandom) >> $urandom_range(0, 23);
      1: b.mag = 24'h7FF800 | 24'($urandom_range(0, 2047));
      2: b.mag = 24'h1 << $urandom_range(0, 23);
      3: b.mag = 24'($urandom_range(0, 3)) << 11 | 24'h400000;
      default: b.mag = 24'($urandom);
    endcase
    return b;
  endfunction

  int lat;

  initial begin
    rst = 1; in_valid = 0; in_sign = 0; in_mag = 0; in_exp = 0;
    out_ready = 1; prev_stall = 0; prev_out = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'(cur_out()), 32'd0);

    in_valid = 1; in_sign = 0; in_mag = 24'h400000; in_exp = 7'd15;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'd2);
    chk("lat_beat", 32'(cur_out()), 32'({1'b0, 1'b0, 11'h400, 7'd15}));
    @(negedge clk);

    stim_q.push_back('{1'b0, 24'h800000, 7'd15});
    stim_q.push_back('{1'b0, 24'h000001, 7'd15});
    stim_q.push_back('{1'b1, 24'h7FF800, 7'd15});
    stim_q.push_back('{1'b1, 24'h000000, 7'd15});
    stim_q.push_back('{1'b0, 24'h800000, 7'd63});
    stim_q.push_back('{1'b0, 24'h000001, 7'h40});
    drain();
`ifdef NORM_ROUND_RNE_EN
    chk("rne_model", 32'(model(1'b0, 24'h7FF800, 7'd15)),
        32'({1'b0, 1'b0, 11'h400, 7'd16}));
`else
    chk("trunc_model", 32'(model(1'b0, 24'h7FF800, 7'd15)),
        32'({1'b0, 1'b0, 11'h7FF, 7'd15}));
`endif
    chk("model_lsb", 32'(model(1'b0, 24'h000001, 7'd15)),
        32'({1'b0, 1'b0, 11'h400, 7'b1111001}));

    for (int i = 0; i < 8; i++) stim_q.push_back(rnd_beat());
    for (int c = 0; c < 40 && (stim_q.size() > 0 || exp_q.size() > 0); c++)
      step(1'(c % 2));
    drain();

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0 && stim_q.size() < 2)
        stim_q.push_back(rnd_beat());
      step(1'($urandom_range(0, 2) != 0));
    end
    drain();

    stim_q.push_back(rnd_beat());
    stim_q.push_back(rnd_beat());
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1;
    in_valid = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out", 32'(cur_out()), 32'd0);
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    stim_q.delete();
    prev_stall = 0;
    for (int c = 0; c < 10; c++) step(1'b1);
    chk("no_stale", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
